// File: rtl/adc_fft_axi_framer.sv
// adc_fft_axi_framer
// Turns the free-running dual-channel ADC stream into fixed-length complex
// frames for an FFT core. One lane is selected, optionally decimated, and
// sign-extended to {imag=0, real}. Each frame is exactly 2^FFT_LEN_LOG2
// beats, and tlast marks the final beat. A small first-word-fall-through
// FIFO absorbs FFT backpressure. The ADC side cannot be stalled, so a
// sample that meets a full FIFO is dropped and a sticky overflow flag is set.
module adc_fft_axi_framer #(
  parameter int ADC_WIDTH        = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int FFT_LEN_LOG2     = 10,
  parameter int FIFO_DEPTH_LOG2  = 4
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_IN_tdata,
  input  logic                        S_AXIS_IN_tvalid,
  input  logic                        cfg_arm,
  input  logic                        cfg_continuous,
  input  logic                        cfg_chan_sel,
  input  logic [7:0]                  cfg_decim,
  input  logic                        clear_ovf,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_OUT_tdata,
  output logic                        M_AXIS_OUT_tvalid,
  input  logic                        M_AXIS_OUT_tready,
  output logic                        M_AXIS_OUT_tlast,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        overflow
);

  localparam int HALF  = AXIS_TDATA_WIDTH / 2;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  // Index of the last beat in a frame (N-1) is all ones.
  localparam logic [FFT_LEN_LOG2-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQ,
    ST_FLUSH
  } state_e;

  typedef struct packed {
    logic            last;
    logic [HALF-1:0] re;
  } entry_t;

  // Control state
  state_e                  state_q, state_d;
  logic                    arm_q;
  logic                    sel_q;
  logic [7:0]              decim_q;
  logic [7:0]              dcnt_q, dcnt_d;
  logic                    take;
  logic [FFT_LEN_LOG2-1:0] in_cnt_q;

  // Capture stage between the ADC lane and the FIFO write port
  logic                    pipe_vld_q;
  logic [HALF-1:0]         pipe_re_q;

  // Output FIFO
  entry_t                     mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_LOG2:0]   count_q;
  entry_t                     head;

  logic ovf_q;
  logic done_q;

  // Derived handshakes
  logic            arm_rise;
  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;
  logic            wr_fire;
  logic            drop;
  logic            wr_last;
  logic            tail_hs;
  logic            frame_start;
  logic [HALF-1:0] lane;
  logic [HALF-1:0] sample_re;
  logic            unused_lane_bits;

  assign arm_rise   = cfg_arm & ~arm_q;
  assign fifo_empty = (count_q == '0);
  // The count never exceeds DEPTH, so its top bit alone means full.
  assign fifo_full  = count_q[FIFO_DEPTH_LOG2];
  assign head       = mem_q[rd_ptr_q];
  assign pop        = ~fifo_empty & M_AXIS_OUT_tready;
  // A write into a full FIFO is fine when the head leaves in the same cycle.
  assign wr_fire    = pipe_vld_q & (~fifo_full | pop);
  assign drop       = pipe_vld_q & fifo_full & ~pop;
  assign wr_last    = (in_cnt_q == LAST_IDX);
  assign tail_hs    = pop & head.last;
  assign frame_start = (state_q != ST_ACQ) && (state_d == ST_ACQ);

  // Lane select and sign extension of the ADC_WIDTH-bit two's complement sample
  assign lane      = sel_q ? S_AXIS_IN_tdata[AXIS_TDATA_WIDTH-1:HALF]
                           : S_AXIS_IN_tdata[HALF-1:0];
  assign sample_re = {{(HALF-ADC_WIDTH){lane[ADC_WIDTH-1]}}, lane[ADC_WIDTH-1:0]};
  // The padding bits above the ADC word carry no information.
  assign unused_lane_bits = ^lane[HALF-1:ADC_WIDTH];

  // Next-state, sample-take and decimation-counter logic
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves a latch behind.
    state_d = state_q;
    dcnt_d  = dcnt_q;
    take    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arm_rise) begin
          state_d = ST_ACQ;
          dcnt_d  = '0;
        end
      end
      ST_ACQ: begin
        // When the Nth sample lands in the FIFO, nothing further is taken.
        if (wr_fire && wr_last) begin
          state_d = ST_FLUSH;
        end else if (S_AXIS_IN_tvalid) begin
          if (dcnt_q == '0) begin
            take   = 1'b1;
            dcnt_d = decim_q;
          end else begin
            dcnt_d = dcnt_q - 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (tail_hs) begin
          state_d = cfg_continuous ? ST_ACQ : ST_IDLE;
          dcnt_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, arm edge detector and per-frame configuration snapshot
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      arm_q   <= 1'b0;
      sel_q   <= 1'b0;
      decim_q <= '0;
      dcnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register updates from pre-edge values.
      state_q <= state_d;
      arm_q   <= cfg_arm;
      dcnt_q  <= dcnt_d;
      if (frame_start) begin
        sel_q   <= cfg_chan_sel;
        decim_q <= cfg_decim;
      end
    end
  end

  // Capture stage: holds the taken sample for one cycle before the FIFO write
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pipe_vld_q <= 1'b0;
      pipe_re_q  <= '0;
    end else begin
      pipe_vld_q <= take;
      if (take) begin
        pipe_re_q <= sample_re;
      end
    end
  end

  // Count of samples actually written in this frame (dropped ones do not count)
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      in_cnt_q <= '0;
    end else if (frame_start) begin
      in_cnt_q <= '0;
    end else if (wr_fire) begin
      in_cnt_q <= in_cnt_q + 1'b1;
    end
  end

  // FIFO storage
  // NOTE: storage is not reset. Visibility comes from the reset count, so stale entries are never presented.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= '{last: wr_last, re: pipe_re_q};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({wr_fire, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow (a new drop wins over clear) and the frame-complete pulse
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clear_ovf) begin
        ovf_q <= 1'b0;
      end
      done_q <= tail_hs;
    end
  end

  assign M_AXIS_OUT_tvalid = ~fifo_empty;
  assign M_AXIS_OUT_tlast  = ~fifo_empty & head.last;
  assign M_AXIS_OUT_tdata  = fifo_empty ? '0
                                        : {{(AXIS_TDATA_WIDTH-HALF){1'b0}}, head.re};
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_adc_fft_axi_framer.sv
// Testbench for adc_fft_axi_framer. Random and directed ADC streams are
// checked against a frame model that is built from the sample stream:
// after arming, every (decim+1)-th valid sample is taken, the first N
// taken samples form the frame, and the lane's 14-bit value is read as a
// signed number.
module tb_adc_fft_axi_framer;

  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [31:0] S_AXIS_IN_tdata;
  logic        S_AXIS_IN_tvalid;
  logic        cfg_arm;
  logic        cfg_continuous;
  logic        cfg_chan_sel;
  logic [7:0]  cfg_decim;
  logic        clear_ovf;
  logic [31:0] M_AXIS_OUT_tdata;
  logic        M_AXIS_OUT_tvalid;
  logic        M_AXIS_OUT_tready;
  logic        M_AXIS_OUT_tlast;
  logic        busy;
  logic        frame_done;
  logic        overflow;

  always #5 clk = ~clk;

  adc_fft_axi_framer dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .S_AXIS_IN_tdata   (S_AXIS_IN_tdata),
    .S_AXIS_IN_tvalid  (S_AXIS_IN_tvalid),
    .cfg_arm           (cfg_arm),
    .cfg_continuous    (cfg_continuous),
    .cfg_chan_sel      (cfg_chan_sel),
    .cfg_decim         (cfg_decim),
    .clear_ovf         (clear_ovf),
    .M_AXIS_OUT_tdata  (M_AXIS_OUT_tdata),
    .M_AXIS_OUT_tvalid (M_AXIS_OUT_tvalid),
    .M_AXIS_OUT_tready (M_AXIS_OUT_tready),
    .M_AXIS_OUT_tlast  (M_AXIS_OUT_tlast),
    .busy              (busy),
    .frame_done        (frame_done),
    .overflow          (overflow)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] got_q[$];
  logic        last_q[$];
  logic [31:0] exp_q[$];
  logic        busy_at_done[$];
  int          done_cnt  = 0;
  int          tlast_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected output beat for an ADC lane value: low 14 bits as a signed number, imag = 0
  function automatic logic [31:0] model_beat(input logic [15:0] lane);
    int v;
    v = int'(lane & 16'h3FFF);
    if (v >= 8192) v = v - 16384;
    return {16'h0000, 16'(v)};
  endfunction

  // Output monitor: collects handshaken beats and checks AXIS hold rules while stalled
  bit          stall_prev = 1'b0;
  logic [31:0] data_prev;
  logic        last_prev;
  initial begin
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", M_AXIS_OUT_tvalid, 1);
          check("hold_data", M_AXIS_OUT_tdata, data_prev);
          check("hold_last", M_AXIS_OUT_tlast, last_prev);
        end
        if (M_AXIS_OUT_tvalid && M_AXIS_OUT_tready) begin
          got_q.push_back(M_AXIS_OUT_tdata);
          last_q.push_back(M_AXIS_OUT_tlast);
          if (M_AXIS_OUT_tlast) tlast_cnt++;
        end
        if (frame_done) begin
          done_cnt++;
          busy_at_done.push_back(busy);
        end
        stall_prev = M_AXIS_OUT_tvalid && !M_AXIS_OUT_tready;
        data_prev  = M_AXIS_OUT_tdata;
        last_prev  = M_AXIS_OUT_tlast;
      end
    end
  end

  task automatic clear_capture();
    got_q.delete();
    last_q.delete();
    exp_q.delete();
    busy_at_done.delete();
    done_cnt  = 0;
    tlast_cnt = 0;
  endtask

  // One single-shot frame. mode 0: ramp on the selected lane, 1: random, 2: random with full-scale edges first
  task automatic run_frame(input string tag, input bit sel, input int decim, input int mode,
                           input int vpct, input int rpct);
    int nvalid, taken, cyc, first_take, first_obs, n, nerr;
    logic [15:0] l1, l2;
    bit v;
    clear_capture();
    cfg_chan_sel      = sel;
    cfg_decim         = 8'(decim);
    cfg_continuous    = 1'b0;
    M_AXIS_OUT_tready = 1'b1;
    // Samples offered while idle, and on the arming edge itself, must be ignored
    repeat (4) begin
      S_AXIS_IN_tdata  = $urandom;
      S_AXIS_IN_tvalid = 1'b1;
      tick();
    end
    cfg_arm = 1'b1;
    tick();
    check({tag, "_busy_start"}, busy, 1);
    cfg_arm    = 1'b0;
    nvalid     = 0;
    taken      = 0;
    cyc        = 0;
    first_take = -1;
    first_obs  = -1;
    while (got_q.size() < N && cyc < 20000) begin
      v  = ($urandom_range(99) < vpct);
      l1 = 16'($urandom);
      l2 = 16'($urandom);
      if (mode == 0) begin
        if (sel) l2 = 16'(nvalid); else l1 = 16'(nvalid);
      end else if (mode == 2 && nvalid < 2) begin
        if (sel) l2 = (nvalid == 0) ? 16'h2000 : 16'h1FFF;
        else     l1 = (nvalid == 0) ? 16'h2000 : 16'h1FFF;
      end
      S_AXIS_IN_tdata   = {l2, l1};
      S_AXIS_IN_tvalid  = v;
      M_AXIS_OUT_tready = ($urandom_range(99) < rpct);
      if (v && taken < N) begin
        if (nvalid % (decim + 1) == 0) begin
          exp_q.push_back(model_beat(sel ? l2 : l1));
          if (taken == 0) first_take = cyc;
          taken++;
        end
        nvalid++;
      end
      tick();
      if (first_obs < 0 && M_AXIS_OUT_tvalid) first_obs = cyc;
      cyc++;
    end
    S_AXIS_IN_tvalid  = 1'b0;
    M_AXIS_OUT_tready = 1'b1;
    repeat (6) tick();
    n = got_q.size();
    check({tag, "_beats"}, n, N);
    check({tag, "_tlast_count"}, tlast_cnt, 1);
    check({tag, "_frame_done"}, done_cnt, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_latency"}, first_obs - first_take, 1);
    nerr = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= exp_q.size() || got_q[i] !== exp_q[i] || last_q[i] !== (i == N - 1)) begin
        if (nerr < 3 && i < exp_q.size())
          $display("  %s beat %0d: data %h last %0b, model %h", tag, i, got_q[i], last_q[i], exp_q[i]);
        nerr++;
      end
    end
    check({tag, "_beat_errors"}, nerr, 0);
  endtask

  // Backpressure: tready low for 40 cycles while the ADC keeps streaming a ramp
  task automatic run_stall();
    int cyc, ramp, n, gaps;
    clear_capture();
    cfg_chan_sel      = 1'b0;
    cfg_decim         = 8'd0;
    S_AXIS_IN_tvalid  = 1'b0;
    M_AXIS_OUT_tready = 1'b1;
    cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
    cyc  = 0;
    ramp = 0;
    while (got_q.size() < N && cyc < 20000) begin
      S_AXIS_IN_tdata   = {16'($urandom), 16'(ramp)};
      S_AXIS_IN_tvalid  = 1'b1;
      M_AXIS_OUT_tready = !(cyc >= 100 && cyc < 140);
      ramp++;
      tick();
      cyc++;
    end
    S_AXIS_IN_tvalid  = 1'b0;
    M_AXIS_OUT_tready = 1'b1;
    repeat (6) tick();
    n = got_q.size();
    check("stall_beats", n, N);
    check("stall_tlast_count", tlast_cnt, 1);
    check("stall_overflow", overflow, 1);
    gaps = 0;
    for (int i = 1; i < n; i++) if (got_q[i] - got_q[i-1] != 32'd1) gaps++;
    check("stall_gap_runs", gaps, 1);
    if (n > 0) begin
      check("stall_first", got_q[0], 32'd0);
      // From one buffered entry in steady state, 15 more fit and the other 25 stalled cycles drop
      check("stall_final", got_q[n-1], 32'd1048);
      check("stall_last_flag", last_q[n-1], 1);
    end
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);
  endtask

  // Back-to-back frames with arm held; continuous dropped during the third frame
  task automatic run_continuous();
    int cyc, n, lerr, serr;
    clear_capture();
    cfg_chan_sel      = 1'b0;
    cfg_decim         = 8'd1;
    cfg_continuous    = 1'b1;
    M_AXIS_OUT_tready = 1'b1;
    cfg_arm           = 1'b1;
    cyc = 0;
    while (tlast_cnt < 3 && cyc < 20000) begin
      S_AXIS_IN_tdata  = {16'($urandom), 16'(cyc)};
      S_AXIS_IN_tvalid = 1'b1;
      tick();
      cyc++;
      if (tlast_cnt >= 2) cfg_continuous = 1'b0;
    end
    S_AXIS_IN_tvalid = 1'b0;
    repeat (6) tick();
    n = got_q.size();
    check("cont_beats", n, 3 * N);
    check("cont_tlast_count", tlast_cnt, 3);
    check("cont_frame_done", done_cnt, 3);
    check("cont_busy_end", busy, 0);
    if (busy_at_done.size() == 3) begin
      check("cont_busy_f1", busy_at_done[0], 1);
      check("cont_busy_f2", busy_at_done[1], 1);
      check("cont_busy_f3", busy_at_done[2], 0);
    end else begin
      check("cont_done_pulses", busy_at_done.size(), 3);
    end
    lerr = 0;
    serr = 0;
    for (int i = 0; i < n; i++) begin
      if (last_q[i] !== ((i % N) == N - 1)) lerr++;
      if (i % N != 0 && got_q[i] - got_q[i-1] != 32'd2) serr++;
    end
    check("cont_tlast_pos", lerr, 0);
    check("cont_decim_step", serr, 0);
    cfg_arm = 1'b0;
    tick();
  endtask

  // Reset in the middle of a frame, then a clean frame
  task automatic run_reset_midframe();
    int cyc;
    clear_capture();
    cfg_chan_sel      = 1'b0;
    cfg_decim         = 8'd0;
    M_AXIS_OUT_tready = 1'b1;
    S_AXIS_IN_tvalid  = 1'b0;
    cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
    cyc = 0;
    while (got_q.size() < 500 && cyc < 5000) begin
      S_AXIS_IN_tdata  = {16'($urandom), 16'(cyc)};
      S_AXIS_IN_tvalid = 1'b1;
      tick();
      cyc++;
    end
    check("rst_reached_500", got_q.size() >= 500, 1);
    aresetn = 1'b0;
    #1;
    check("rst_tvalid", M_AXIS_OUT_tvalid, 0);
    check("rst_tdata", M_AXIS_OUT_tdata, 32'h0);
    check("rst_tlast", M_AXIS_OUT_tlast, 0);
    check("rst_busy", busy, 0);
    S_AXIS_IN_tvalid = 1'b0;
    repeat (2) tick();
    check("rst_tvalid_held", M_AXIS_OUT_tvalid, 0);
    aresetn = 1'b1;
    repeat (2) tick();
    check("rst_no_tlast", tlast_cnt, 0);
    check("rst_still_empty", M_AXIS_OUT_tvalid, 0);
    run_frame("after_reset", 1'b0, 0, 0, 100, 100);
  endtask

  // Global time bound
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn           = 1'b0;
    S_AXIS_IN_tdata   = '0;
    S_AXIS_IN_tvalid  = 1'b0;
    cfg_arm           = 1'b0;
    cfg_continuous    = 1'b0;
    cfg_chan_sel      = 1'b0;
    cfg_decim         = 8'd0;
    clear_ovf         = 1'b0;
    M_AXIS_OUT_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tvalid", M_AXIS_OUT_tvalid, 0);
    check("reset_tlast", M_AXIS_OUT_tlast, 0);
    check("reset_tdata", M_AXIS_OUT_tdata, 32'h0);
    check("reset_busy", busy, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_overflow", overflow, 0);
    aresetn = 1'b1;
    tick();

    run_frame("ramp_ch1", 1'b0, 0, 0, 100, 100);

    run_frame("ch2_fullscale", 1'b1, 0, 2, 100, 100);
    if (got_q.size() >= 2) begin
      check("ch2_neg_fullscale", got_q[0], 32'h0000E000);
      check("ch2_pos_fullscale", got_q[1], 32'h00001FFF);
    end else begin
      check("ch2_fullscale_beats", got_q.size(), N);
    end

    run_frame("decim3_ramp", 1'b0, 3, 0, 100, 100);

    run_stall();

    run_continuous();

    run_reset_midframe();

    for (int k = 0; k < 4; k++) begin
      run_frame($sformatf("rand%0d", k), 1'($urandom_range(1)), $urandom_range(2), 1,
                $urandom_range(60, 30), $urandom_range(100, 80));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
